cpu_run_ctrl: RTL and testbench

Parametrised run-control and statistics unit for the single-cycle RISC-V core. It replaces the fixed divider/mux/counter clocking with a single-clock design that produces a one-cycle CPU clock-enable pulse (cpu_en) at a selectable rate. It adds free-run, single-step and halt/resume modes, a saturating executed-instruction counter, and 2**STAT_SEL_W per-event statistics counters. These counters are read through a selector for the seven-segment display path.

---
 rtl/cpu_run_ctrl.sv | 128 ++++++++++++
 tb/tb_cpu_run_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// Run-control for the single-cycle core: rate-selectable commit enable, free-run/step/halt
// modes, saturating instruction counter and per-event statistics counters.
module cpu_run_ctrl #(
  parameter int unsigned DIV0       = 50000000,
  parameter int unsigned DIV1       = 5000000,
  parameter int unsigned DIV2       = 1000000,
  parameter int unsigned DIV3       = 500000,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned STAT_SEL_W = 2
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [1:0]                  Rate_Sel,
  input  logic                        Step_Mode,
  input  logic                        Go,
  input  logic                        halt_req,
  input  logic [2**STAT_SEL_W-1:0]    ev,
  input  logic                        Clr_Stats,
  input  logic [STAT_SEL_W-1:0]       Stat_Sel,
  output logic                        cpu_en,
  output logic                        Running,
  output logic                        Halted,
  output logic [CNT_W-1:0]            Instr_Cnt,
  output logic [CNT_W-1:0]            Stat_Out
);

  localparam int unsigned NCH = 2**STAT_SEL_W;

  typedef enum logic [1:0] {StRun, StStepIdle, StArmed, StHalt} state_e;

  state_e      state_q, state_d;
  logic        cpu_en_q, cpu_en_d;
  logic [2:0]  go_sync_q;
  logic        go_pulse;
  logic [1:0]  rate_q;
  logic [31:0] div_cnt_q, div_cnt_d, div_last;
  logic        rate_chg, tick;
  logic [CNT_W-1:0] instr_q, instr_d, stat_q;
  logic [CNT_W-1:0] ev_cnt_q [NCH];
  logic [CNT_W-1:0] ev_cnt_d [NCH];

  // Two synchroniser flops plus one delay flop for rising-edge detection.
  assign go_pulse = go_sync_q[1] & ~go_sync_q[2];

  always_comb begin
    case (rate_q)
      2'd0:    div_last = DIV0 - 1;
      2'd1:    div_last = DIV1 - 1;
      2'd2:    div_last = DIV2 - 1;
      default: div_last = DIV3 - 1;
    endcase
    rate_chg  = (Rate_Sel != rate_q);
    tick      = !rate_chg && (div_cnt_q == div_last);
    div_cnt_d = (rate_chg || tick) ? 32'd0 : div_cnt_q + 32'd1;
  end

  always_comb begin
    state_d  = state_q;
    cpu_en_d = 1'b0;
    unique case (state_q)
      StRun: begin
        if (Step_Mode) begin
          state_d = StStepIdle;
        end else if (tick) begin
          if (halt_req) state_d = StHalt;
          else          cpu_en_d = 1'b1;
        end
      end
      StStepIdle: begin
        if (!Step_Mode)    state_d = StRun;
        else if (go_pulse) state_d = StArmed;
      end
      StHalt: begin
        if (go_pulse) state_d = StArmed;
      end
      StArmed: begin
        // Resume commits the halting instruction regardless of halt_req.
        if (tick) begin
          cpu_en_d = 1'b1;
          state_d  = Step_Mode ? StStepIdle : StRun;
        end
      end
    endcase
  end

  always_comb begin
    instr_d = instr_q;
    for (int i = 0; i < NCH; i++) ev_cnt_d[i] = ev_cnt_q[i];
    if (Clr_Stats) begin
      instr_d = '0;
      for (int i = 0; i < NCH; i++) ev_cnt_d[i] = '0;
    end else if (cpu_en_q) begin
      if (instr_q != '1) instr_d = instr_q + 1'b1;
      for (int i = 0; i < NCH; i++) begin
        if (ev[i] && (ev_cnt_q[i] != '1)) ev_cnt_d[i] = ev_cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StRun;
      cpu_en_q  <= 1'b0;
      go_sync_q <= '0;
      rate_q    <= Rate_Sel;
      div_cnt_q <= '0;
      instr_q   <= '0;
      stat_q    <= '0;
      for (int i = 0; i < NCH; i++) ev_cnt_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cpu_en_q  <= cpu_en_d;
      go_sync_q <= {go_sync_q[1:0], Go};
      rate_q    <= Rate_Sel;
      div_cnt_q <= div_cnt_d;
      instr_q   <= instr_d;
      stat_q    <= ev_cnt_d[Stat_Sel];
      for (int i = 0; i < NCH; i++) ev_cnt_q[i] <= ev_cnt_d[i];
    end
  end

  assign cpu_en    = cpu_en_q;
  assign Running   = (state_q == StRun);
  assign Halted    = (state_q == StHalt);
  assign Instr_Cnt = instr_q;
  assign Stat_Out  = stat_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: a cycle-level reference model predicts outputs that a
// separate monitor compares after every clock edge.
module tb_cpu_run_ctrl;

  localparam int NCH  = 4;
  localparam int MAXV = 15;

  logic       CLK = 1'b0;
  logic       RST, Step_Mode, Go, halt_req, Clr_Stats;
  logic [1:0] Rate_Sel, Stat_Sel;
  logic [3:0] ev;
  logic       cpu_en, Running, Halted;
  logic [3:0] Instr_Cnt, Stat_Out;

  always #5 CLK = ~CLK;

  cpu_run_ctrl #(
    .DIV0(4), .DIV1(2), .DIV2(3), .DIV3(1), .CNT_W(4), .STAT_SEL_W(2)
  ) dut (
    .CLK(CLK), .RST(RST), .Rate_Sel(Rate_Sel), .Step_Mode(Step_Mode), .Go(Go),
    .halt_req(halt_req), .ev(ev), .Clr_Stats(Clr_Stats), .Stat_Sel(Stat_Sel),
    .cpu_en(cpu_en), .Running(Running), .Halted(Halted), .Instr_Cnt(Instr_Cnt),
    .Stat_Out(Stat_Out)
  );

  typedef struct {
    int en;
    int run;
    int hlt;
    int ic;
    int so;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model in terms of the behavioural rules.
  localparam int MRun = 0, MStepIdle = 1, MArmed = 2, MHalt = 3;
  int div_of [4] = '{4, 2, 3, 1};
  int m_mode, m_since, m_rate, m_instr, m_stat;
  int m_ev [NCH];
  bit m_en;
  bit m_go_hist [3];

  function automatic int sat_inc(input int v);
    return (v >= MAXV) ? MAXV : v + 1;
  endfunction

  task automatic model_step();
    bit   pulse, tick, fire;
    exp_t e;
    if (RST) begin
      m_mode = MRun; m_since = 0; m_rate = int'(Rate_Sel); m_en = 0;
      m_instr = 0; m_stat = 0;
      for (int c = 0; c < NCH; c++) m_ev[c] = 0;
      for (int k = 0; k < 3; k++) m_go_hist[k] = 0;
    end else begin
      pulse = m_go_hist[1] && !m_go_hist[2];
      m_go_hist[2] = m_go_hist[1];
      m_go_hist[1] = m_go_hist[0];
      m_go_hist[0] = Go;
      if (int'(Rate_Sel) != m_rate) begin
        m_rate = int'(Rate_Sel); m_since = 0; tick = 0;
      end else begin
        tick    = (m_since + 1 == div_of[m_rate]);
        m_since = tick ? 0 : m_since + 1;
      end
      if (Clr_Stats) begin
        m_instr = 0;
        for (int c = 0; c < NCH; c++) m_ev[c] = 0;
      end else if (m_en) begin
        m_instr = sat_inc(m_instr);
        for (int c = 0; c < NCH; c++) if (ev[c]) m_ev[c] = sat_inc(m_ev[c]);
      end
      m_stat = m_ev[Stat_Sel];
      fire = 0;
      case (m_mode)
        MRun:      if (Step_Mode) m_mode = MStepIdle;
                   else if (tick) begin
                     if (halt_req) m_mode = MHalt;
                     else          fire = 1;
                   end
        MStepIdle: if (!Step_Mode) m_mode = MRun;
                   else if (pulse) m_mode = MArmed;
        MHalt:     if (pulse) m_mode = MArmed;
        default:   if (tick) begin
                     fire = 1;
                     m_mode = Step_Mode ? MStepIdle : MRun;
                   end
      endcase
      m_en = fire;
    end
    e.en  = int'(m_en);
    e.run = (m_mode == MRun) ? 1 : 0;
    e.hlt = (m_mode == MHalt) ? 1 : 0;
    e.ic  = m_instr;
    e.so  = m_stat;
    sb_q.push_back(e);
  endtask

  // Inputs are changed only at the falling edge; model predicts the next rising edge.
  task automatic cyc(input int n);
    repeat (n) begin
      model_step();
      @(negedge CLK);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  always @(posedge CLK) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("cpu_en",    int'(cpu_en),    e.en);
      chk("Running",   int'(Running),   e.run);
      chk("Halted",    int'(Halted),    e.hlt);
      chk("Instr_Cnt", int'(Instr_Cnt), e.ic);
      chk("Stat_Out",  int'(Stat_Out),  e.so);
    end
  end

  task automatic set_in(input bit rst, input int rate, input bit step, input bit go,
                        input bit hr, input int evv, input bit clr, input int sel);
    RST = rst; Rate_Sel = 2'(rate); Step_Mode = step; Go = go; halt_req = hr;
    ev = 4'(evv); Clr_Stats = clr; Stat_Sel = 2'(sel);
  endtask

  initial begin
    set_in(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(2);
    // Free run at DIV0, random events.
    for (int i = 0; i < 16; i++) begin
      set_in(0, 0, 0, 0, 0, int'($urandom_range(0, 15)), 0, i % 4);
      cyc(1);
    end
    // Rate change mid-count.
    set_in(0, 1, 0, 0, 0, 3, 0, 1);
    cyc(10);
    // Halt, then resume with Go held 5 cycles, then a stray press while running.
    set_in(0, 1, 0, 0, 1, 0, 0, 0);
    cyc(6);
    halt_req = 0; Go = 1;
    cyc(5);
    Go = 0;
    cyc(10);
    Go = 1;
    cyc(3);
    Go = 0;
    cyc(8);
    // Single step: idle, then three presses.
    Step_Mode = 1;
    cyc(20);
    for (int p = 0; p < 3; p++) begin
      Go = 1;
      cyc(2);
      Go = 0;
      cyc(6);
    end
    // Saturation at DIV3=1 with ev=0101.
    set_in(1, 3, 0, 0, 0, 5, 0, 0);
    cyc(1);
    set_in(0, 3, 0, 0, 0, 5, 0, 0);
    cyc(20);
    Stat_Sel = 2;
    cyc(4);
    Stat_Sel = 1;
    cyc(2);
    // Clear racing a commit.
    Clr_Stats = 1;
    cyc(1);
    Clr_Stats = 0;
    cyc(3);
    // Reset while armed after a halt.
    set_in(0, 0, 0, 0, 1, 0, 0, 0);
    cyc(8);
    halt_req = 0; Go = 1;
    cyc(3);
    RST = 1;
    cyc(1);
    RST = 0; Go = 0;
    cyc(10);
    // Randomised mix.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 49) == 0) Rate_Sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 79) == 0) Step_Mode = ~Step_Mode;
      if ($urandom_range(0, 5) == 0) Go = ~Go;
      halt_req  = ($urandom_range(0, 9) == 0);
      ev        = 4'($urandom_range(0, 15));
      Clr_Stats = ($urandom_range(0, 99) == 0);
      RST       = ($urandom_range(0, 299) == 0);
      Stat_Sel  = 2'($urandom_range(0, 3));
      cyc(1);
    end
    @(posedge CLK);
    #2;
    chk("sb_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
